skinny_sbox8_hpc2_d_str_hs: RTL and testbench

- Masked SKINNY-128 8-bit S-box built from HPC2 AND gadgets, generalised to NS Boolean shares (order d = NS-1).
- Adds a valid/ready handshake and an internal control FSM, so the caller no longer holds inputs and randomness stable.
- Sits between the masked state register and the MixColumns/AddRoundTweakey datapath. One S-box evaluation in flight at a time.

---
 rtl/skinny_sbox8_hpc2_d_str_hs.sv | 171 +++++++++++++++++
 tb/tb_skinny_sbox8_hpc2_d_str_hs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_hpc2_d_str_hs.sv
// Masked SKINNY-128 8-bit S-box built from NS-share HPC2 AND gadgets,
// with a valid/ready handshake and an IDLE/BUSY/DONE control FSM.
// Optional macro SKINNY_SBOX_OUT_REFRESH_EN adds the r_out port and
// refreshes the output shares at the capture edge.
// Each layer computes f = (~x & ~y) ^ z. Complements go on share 0 only.
// The L0 first-stage registers load straight from si/r on the acceptance
// edge. From then on they reload identical values from the latched copies.
// This lets all four 2-cycle layers fit inside the 8 BUSY cycles.
module skinny_sbox8_hpc2_d_str_hs #(
  parameter  int NS = 2,
  localparam int RW = 4 * NS * (NS - 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8*NS-1:0] si,
  input  logic [RW-1:0]   r,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [8*NS-1:0] bo,
  output logic            out_valid,
  input  logic            out_ready
`ifdef SKINNY_SBOX_OUT_REFRESH_EN
  ,
  input  logic [8*(NS-1)-1:0] r_out
`endif
);

  localparam int NP = NS * (NS - 1) / 2;
  localparam logic [NS-1:0] SH0 = {{(NS - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Position of the shared random bit r_ij (i < j) inside one gadget's slice.
  function automatic int pair_idx(input int i, input int j);
    return i * NS - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  state_t          r_state, w_next;
  logic [2:0]      r_cnt;
  logic [8*NS-1:0] r_si, r_bo;
  logic [RW-1:0]   r_rnd;
  logic            w_accept, w_capture;
  logic [8*NS-1:0] w_src_si, w_res, w_mask;
  logic [RW-1:0]   w_src_r;

  logic [NS-1:0] w_b [8];
  logic [NS-1:0] w_x [8];
  logic [NS-1:0] w_y [8];
  logic [NS-1:0] w_z [8];
  logic [NS-1:0] w_a [8];

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bo        = r_bo;
  assign w_accept  = in_ready & in_valid;
  assign w_capture = (r_state == S_BUSY) && (r_cnt == 3'd7);
  assign w_src_si  = w_accept ? si : r_si;
  assign w_src_r   = w_accept ? r  : r_rnd;

  // Regroup the packed shares into per-bit share vectors.
  for (genvar k = 0; k < 8; k++) begin : g_bit
    for (genvar i = 0; i < NS; i++) begin : g_sh
      assign w_b[k][i] = w_src_si[8*i+k];
    end
  end

  // Layer schedule: gadget g produces a_g = f(x_g, y_g, z_g).
  assign w_x[0] = w_b[7]; assign w_y[0] = w_b[6]; assign w_z[0] = w_b[4];
  assign w_x[1] = w_b[3]; assign w_y[1] = w_b[2]; assign w_z[1] = w_b[0];
  assign w_x[2] = w_b[2]; assign w_y[2] = w_b[1]; assign w_z[2] = w_b[6];
  assign w_x[3] = w_a[0]; assign w_y[3] = w_a[1]; assign w_z[3] = w_b[5];
  assign w_x[4] = w_a[1]; assign w_y[4] = w_b[3]; assign w_z[4] = w_b[1];
  assign w_x[5] = w_a[2]; assign w_y[5] = w_a[3]; assign w_z[5] = w_b[7];
  assign w_x[6] = w_a[3]; assign w_y[6] = w_a[0]; assign w_z[6] = w_b[3];
  assign w_x[7] = w_a[4]; assign w_y[7] = w_a[5]; assign w_z[7] = w_b[2];

  // HPC2 gadgets. The operands are ~x and ~y.
  // The cross product for share pair (i, j) is kept in a register of its own.
  // The diagonal element carries b_i with no mask, which gives the a_i*b_i term.
  for (genvar g = 0; g < 8; g++) begin : g_and
    logic [NS-1:0] w_ga, w_gb, w_c;
    assign w_ga = w_x[g] ^ SH0;
    assign w_gb = w_y[g] ^ SH0;
    for (genvar i = 0; i < NS; i++) begin : g_i
      logic [NS-1:0] w_uv;
      for (genvar j = 0; j < NS; j++) begin : g_j
        logic w_rnd, r_rb, r_rr, r_u, r_v;
        if (i == j) begin : g_diag
          assign w_rnd = 1'b0;
        end else begin : g_off
          assign w_rnd = w_src_r[g*NP + pair_idx((i < j) ? i : j, (i < j) ? j : i)];
        end
        // Stage 1 registers b_j ^ r_ij and r_ij. Stage 2 gates each of them with a_i.
        // NOTE: gadget registers are cleared on reset as well, so that a stale
        // share from an aborted evaluation never meets fresh randomness.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_rb <= 1'b0;
            r_rr <= 1'b0;
            r_u  <= 1'b0;
            r_v  <= 1'b0;
          end else begin
            r_rb <= w_gb[j] ^ w_rnd;
            r_rr <= w_rnd;
            r_u  <= ~w_ga[i] & r_rr;
            r_v  <= w_ga[i] & r_rb;
          end
        end
        assign w_uv[j] = r_u ^ r_v;
      end
      assign w_c[i] = ^w_uv;
    end
    assign w_a[g] = w_c ^ w_z[g];
  end

  // Output bit map, identical for every share.
  for (genvar i = 0; i < NS; i++) begin : g_out
    assign w_res[8*i +: 8] = {w_a[3][i], w_a[0][i], w_a[1][i], w_a[6][i],
                              w_a[4][i], w_a[2][i], w_a[5][i], w_a[7][i]};
  end

`ifdef SKINNY_SBOX_OUT_REFRESH_EN
  logic [7:0] w_mask0;
  // Share 0 absorbs the XOR of all refresh bytes so the unmasked value is unchanged.
  always_comb begin
    w_mask0 = 8'h00;
    for (int i = 0; i < NS - 1; i++) w_mask0 ^= r_out[8*i +: 8];
  end
  assign w_mask[7:0] = w_mask0;
  for (genvar i = 1; i < NS; i++) begin : g_refresh
    assign w_mask[8*i +: 8] = r_out[8*(i-1) +: 8];
  end
`else
  assign w_mask = '0;
`endif

  // Next-state logic of the handshake FSM.
  // NOTE: w_next gets its default before the case statement, so no branch can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 3'd7) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, cycle counter, latched operands and output capture.
  // NOTE: non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_si    <= '0;
      r_rnd   <= '0;
      r_bo    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_si  <= si;
        r_rnd <= r;
        r_cnt <= 3'd0;
      end else if (r_state == S_BUSY && r_cnt != 3'd7) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_capture) r_bo <= w_res ^ w_mask;
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_hpc2_d_str_hs.sv
// Self-checking bench for skinny_sbox8_hpc2_d_str_hs.
// It drives an NS=2 and an NS=3 instance with randomised shares and randomness.
// Results are compared against an unmasked reference S-box computed inside the bench.
module tb_skinny_sbox8_hpc2_d_str_hs;

  localparam int MAX_LAT = 20;

  logic        clk;
  logic        rst;

  logic [15:0] si2, bo2;
  logic [7:0]  r2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;

  logic [23:0] si3, bo3;
  logic [23:0] r3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3;

  int n_checks = 0;
  int n_errors = 0;

  skinny_sbox8_hpc2_d_str_hs #(.NS(2)) u_dut2 (
    .clk(clk), .rst(rst), .si(si2), .r(r2), .in_valid(in_valid2), .in_ready(in_ready2),
    .bo(bo2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  skinny_sbox8_hpc2_d_str_hs #(.NS(3)) u_dut3 (
    .clk(clk), .rst(rst), .si(si3), .r(r3), .in_valid(in_valid3), .in_ready(in_ready3),
    .bo(bo3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  // Unmasked SKINNY S8 written out as the NOR/XOR layers and the output bit map.
  function automatic logic [7:0] s8_ref(input logic [7:0] b);
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    a0 = ~(b[7] | b[6]) ^ b[4];
    a1 = ~(b[3] | b[2]) ^ b[0];
    a2 = ~(b[2] | b[1]) ^ b[6];
    a3 = ~(a0 | a1) ^ b[5];
    a4 = ~(a1 | b[3]) ^ b[1];
    a5 = ~(a2 | a3) ^ b[7];
    a6 = ~(a3 | a0) ^ b[3];
    a7 = ~(a4 | a5) ^ b[2];
    return {a3, a0, a1, a6, a4, a2, a5, a7};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch2(input logic [15:0] sh, input logic [7:0] rr);
    si2 = sh; r2 = rr; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
  endtask

  // Inputs are scrambled each cycle while busy, including spurious in_valid pulses.
  task automatic wait_out2(output int lat);
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < MAX_LAT) begin
      si2 = 16'($urandom); r2 = 8'($urandom); in_valid2 = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    in_valid2 = 1'b0;
  endtask

  task automatic launch3(input logic [23:0] sh, input logic [23:0] rr);
    si3 = sh; r3 = rr; in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
  endtask

  task automatic wait_out3(output int lat);
    lat = 0;
    while (out_valid3 !== 1'b1 && lat < MAX_LAT) begin
      si3 = 24'($urandom); r3 = 24'($urandom); in_valid3 = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    in_valid3 = 1'b0;
  endtask

  initial begin
    int         lat;
    int         ov_cnt;
    logic [7:0] x, y, m1, m2;

    rst = 1'b1;
    out_ready2 = 1'b1; out_ready3 = 1'b1;
    in_valid2 = 1'b1;  in_valid3 = 1'b1;
    si2 = 16'hA55A; r2 = 8'h3C; si3 = 24'h123456; r3 = 24'hABCDEF;
    repeat (3) step();

    // Reset state. in_valid was high throughout and must not have been accepted.
    check("rst_in_ready2", in_ready2, 1'b1);
    check("rst_out_valid2", out_valid2, 1'b0);
    check("rst_bo2", bo2, 16'h0000);
    check("rst_in_ready3", in_ready3, 1'b1);
    check("rst_out_valid3", out_valid3, 1'b0);
    check("rst_bo3", bo3, 24'h000000);
    rst = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    step();

    // NS=2, all-zero shares and randomness: cycle-by-cycle handshake timing.
    launch2(16'h0000, 8'h00);
    for (int e = 0; e <= 8; e++) begin
      check("zero_busy_in_ready", in_ready2, 1'b0);
      check("zero_out_valid_timing", out_valid2, (e == 8) ? 1'b1 : 1'b0);
      if (e < 8) step();
    end
    check("zero_value", bo2[15:8] ^ bo2[7:0], 8'h65);
    check("zero_value_ref", bo2[15:8] ^ bo2[7:0], s8_ref(8'h00));
    step();
    check("zero_back_to_idle_ready", in_ready2, 1'b1);
    check("zero_back_to_idle_valid", out_valid2, 1'b0);

    // NS=2, value 0xFF as 0x5A/0xA5, then 100 fresh random r and random masks.
    for (int k = 0; k <= 100; k++) begin
      m1 = (k == 0) ? 8'h5A : 8'($urandom);
      launch2({8'hFF ^ m1, m1}, 8'($urandom));
      wait_out2(lat);
      check("ff_latency", lat, 8);
      check("ff_value", bo2[15:8] ^ bo2[7:0], 8'hFF);
      step();
    end

    // NS=3, all 256 inputs with random shares and randomness.
    for (int v = 0; v < 256; v++) begin
      x = 8'(v); m1 = 8'($urandom); m2 = 8'($urandom);
      launch3({x ^ m1 ^ m2, m2, m1}, 24'($urandom));
      wait_out3(lat);
      check("ns3_latency", lat, 8);
      y = bo3[23:16] ^ bo3[15:8] ^ bo3[7:0];
      check("ns3_value", y, s8_ref(x));
      if (v == 1) check("ns3_s8_01", y, 8'h4C);
      step();
    end

    // Back-pressure: DONE held 20 cycles with in_valid asserted.
    out_ready3 = 1'b0;
    x = 8'hB7; m1 = 8'($urandom); m2 = 8'($urandom);
    launch3({x ^ m1 ^ m2, m2, m1}, 24'($urandom));
    wait_out3(lat);
    check("bp_latency", lat, 8);
    for (int c = 0; c < 20; c++) begin
      in_valid3 = 1'b1; si3 = 24'($urandom); r3 = 24'($urandom);
      check("bp_out_valid", out_valid3, 1'b1);
      check("bp_in_ready", in_ready3, 1'b0);
      check("bp_value", bo3[23:16] ^ bo3[15:8] ^ bo3[7:0], s8_ref(x));
      step();
    end
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    step();
    check("bp_release_ready", in_ready3, 1'b1);
    check("bp_release_valid", out_valid3, 1'b0);

    // Reset while BUSY at cnt=4: the result is discarded and nothing is emitted.
    x = 8'h3D; m1 = 8'($urandom); m2 = 8'($urandom);
    launch3({x ^ m1 ^ m2, m2, m1}, 24'($urandom));
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("busy_rst_in_ready", in_ready3, 1'b1);
    check("busy_rst_out_valid", out_valid3, 1'b0);
    check("busy_rst_bo", bo3, 24'h000000);
    ov_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid3 === 1'b1) ov_cnt++;
      step();
    end
    check("busy_rst_no_emit", ov_cnt, 0);
    x = 8'hC4; m1 = 8'($urandom); m2 = 8'($urandom);
    launch3({x ^ m1 ^ m2, m2, m1}, 24'($urandom));
    wait_out3(lat);
    check("after_rst_latency", lat, 8);
    check("after_rst_value", bo3[23:16] ^ bo3[15:8] ^ bo3[7:0], s8_ref(x));
    step();

    // Reset while in DONE on the NS=2 instance.
    out_ready2 = 1'b0;
    x = 8'h9E; m1 = 8'($urandom);
    launch2({x ^ m1, m1}, 8'($urandom));
    wait_out2(lat);
    check("done_rst_pre_value", bo2[15:8] ^ bo2[7:0], s8_ref(x));
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready2 = 1'b1;
    check("done_rst_out_valid", out_valid2, 1'b0);
    check("done_rst_in_ready", in_ready2, 1'b1);
    check("done_rst_bo", bo2, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
